// File: rtl/fpnew_slice_result_buffer.sv
// fpnew_slice_result_buffer
//   Receives the result handshake of an fpnew opgroup slice and stores completed
//   results in a small FIFO. The slice pipeline can keep draining while the
//   writeback stage stalls. The block also accumulates sticky IEEE flags from
//   every entry that is handed downstream.
//
// Ports
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   slc_result_i/status_i/ext_bit_i/tag_i, slc_valid_i, slc_ready_o
//                                    slice-side handshake (push)
//   result_o/status_o/extension_bit_o/tag_o, out_valid_o, out_ready_i
//                                    head entry toward writeback (pop)
//   flush_i                          discard all buffered entries
//   fflags_clr_i                     clear sticky flags
//   fflags_o                         sticky OR of status of popped entries
//   usage_o, busy_o                  occupancy and non-empty indication
module fpnew_slice_result_buffer #(
  parameter int unsigned Width   = 64,
  parameter int unsigned Depth   = 2,
  parameter type         TagType = logic,
  localparam int unsigned CntW   = $clog2(Depth + 1),
  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [Width-1:0]  slc_result_i,
  input  logic [4:0]        slc_status_i,
  input  logic              slc_ext_bit_i,
  input  TagType            slc_tag_i,
  input  logic              slc_valid_i,
  output logic              slc_ready_o,
  output logic [Width-1:0]  result_o,
  output logic [4:0]        status_o,
  output logic              extension_bit_o,
  output TagType            tag_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  input  logic              flush_i,
  input  logic              fflags_clr_i,
  output logic [4:0]        fflags_o,
  output logic [CntW-1:0]   usage_o,
  output logic              busy_o
);

  logic [Width-1:0] res_mem_r [Depth];
  logic [4:0]       sts_mem_r [Depth];
  logic             ext_mem_r [Depth];
  TagType           tag_mem_r [Depth];

  logic [PtrW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CntW-1:0]  cnt_r, cnt_nxt_s;
  logic [4:0]       fflags_r, fflags_nxt_s;
  logic             push_s, pop_s, empty_s;

  // Advance a pointer, wrapping at Depth-1 so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(Depth - 1)) begin
      return {PtrW{1'b0}};
    end else begin
      return ptr + PtrW'(1);
    end
  endfunction

  // Handshake qualifiers; ready depends only on state and flush, never on out_ready_i.
  always_comb begin
    empty_s     = (cnt_r == {CntW{1'b0}});
    slc_ready_o = (cnt_r != CntW'(Depth)) & ~flush_i;
    out_valid_o = ~empty_s;
    push_s      = slc_valid_i & slc_ready_o;
    pop_s       = out_valid_o & out_ready_i;
    usage_o     = cnt_r;
    busy_o      = ~empty_s;
    fflags_o    = fflags_r;
  end

  // Head-entry data; forced to zero when empty so stale slots never leak out.
  always_comb begin
    if (empty_s) begin
      result_o        = {Width{1'b0}};
      status_o        = 5'b00000;
      extension_bit_o = 1'b0;
      tag_o           = TagType'(0);
    end else begin
      result_o        = res_mem_r[rd_ptr_r];
      status_o        = sts_mem_r[rd_ptr_r];
      extension_bit_o = ext_mem_r[rd_ptr_r];
      tag_o           = tag_mem_r[rd_ptr_r];
    end
  end

  // Next occupancy; flush wins over any push/pop in the same cycle.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (flush_i) begin
      cnt_nxt_s = {CntW{1'b0}};
    end else if (push_s && !pop_s) begin
      cnt_nxt_s = cnt_r + CntW'(1);
    end else if (pop_s && !push_s) begin
      cnt_nxt_s = cnt_r - CntW'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Next sticky flags; a pop in the same cycle as a clear seeds the fresh value.
  always_comb begin
    fflags_nxt_s = fflags_r;
    if (pop_s) begin
      fflags_nxt_s = (fflags_clr_i ? 5'b00000 : fflags_r) | status_o;
    end else if (fflags_clr_i) begin
      fflags_nxt_s = 5'b00000;
    end else begin
      fflags_nxt_s = fflags_r;
    end
  end

  // Pointer, count and flag state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      cnt_r    <= {CntW{1'b0}};
      fflags_r <= 5'b00000;
    end else begin
      cnt_r    <= cnt_nxt_s;
      fflags_r <= fflags_nxt_s;
      if (flush_i) begin
        wr_ptr_r <= {PtrW{1'b0}};
        rd_ptr_r <= {PtrW{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= next_ptr(wr_ptr_r);
        end
        if (pop_s) begin
          rd_ptr_r <= next_ptr(rd_ptr_r);
        end
      end
    end
  end

  // Entry storage, written at the write pointer on every accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        res_mem_r[i] <= {Width{1'b0}};
        sts_mem_r[i] <= 5'b00000;
        ext_mem_r[i] <= 1'b0;
        tag_mem_r[i] <= TagType'(0);
      end
    end else if (push_s) begin
      res_mem_r[wr_ptr_r] <= slc_result_i;
      sts_mem_r[wr_ptr_r] <= slc_status_i;
      ext_mem_r[wr_ptr_r] <= slc_ext_bit_i;
      tag_mem_r[wr_ptr_r] <= slc_tag_i;
    end
  end

endmodule

// File: tb/tb_fpnew_slice_result_buffer.sv
// Directed and randomized checks of fpnew_slice_result_buffer: a Depth=2
// instance for directed scenarios, plus Depth 1/3/4 instances under random
// valid/ready traffic compared against a small FIFO model.
module tb_fpnew_slice_result_buffer;

  logic        clk, rst_n;
  logic [63:0] slc_result;
  logic [4:0]  slc_status;
  logic        slc_ext;
  logic [3:0]  slc_tag;
  logic        slc_valid, slc_ready;
  logic [63:0] result;
  logic [4:0]  status;
  logic        ext;
  logic [3:0]  tag;
  logic        out_valid, out_ready, flush, fflags_clr;
  logic [4:0]  fflags;
  logic [1:0]  usage;
  logic        busy;

  int errors, checks;

  fpnew_slice_result_buffer #(.Width(64), .Depth(2), .TagType(logic [3:0])) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slc_result_i(slc_result), .slc_status_i(slc_status), .slc_ext_bit_i(slc_ext),
    .slc_tag_i(slc_tag), .slc_valid_i(slc_valid), .slc_ready_o(slc_ready),
    .result_o(result), .status_o(status), .extension_bit_o(ext), .tag_o(tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .flush_i(flush),
    .fflags_clr_i(fflags_clr), .fflags_o(fflags), .usage_o(usage), .busy_o(busy)
  );

  // Random-traffic instances: index 0 -> Depth 1, 1 -> Depth 3, 2 -> Depth 4
  logic [15:0] r_res_in [3];
  logic [4:0]  r_sts_in [3];
  logic        r_ext_in [3];
  logic [3:0]  r_tag_in [3];
  logic        r_vin [3];
  logic        r_rdy_o [3];
  logic [15:0] r_res [3];
  logic [4:0]  r_sts [3];
  logic        r_ext [3];
  logic [3:0]  r_tag [3];
  logic        r_vout [3];
  logic        r_rdy_in [3];
  logic [4:0]  r_ff [3];
  logic [2:0]  r_usage [3];
  logic        r_busy [3];
  logic        r_zero;

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int unsigned D  = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    localparam int unsigned UW = $clog2(D + 1);
    fpnew_slice_result_buffer #(.Width(16), .Depth(D), .TagType(logic [3:0])) u_rnd (
      .clk_i(clk), .rst_ni(rst_n),
      .slc_result_i(r_res_in[g]), .slc_status_i(r_sts_in[g]), .slc_ext_bit_i(r_ext_in[g]),
      .slc_tag_i(r_tag_in[g]), .slc_valid_i(r_vin[g]), .slc_ready_o(r_rdy_o[g]),
      .result_o(r_res[g]), .status_o(r_sts[g]), .extension_bit_o(r_ext[g]), .tag_o(r_tag[g]),
      .out_valid_o(r_vout[g]), .out_ready_i(r_rdy_in[g]), .flush_i(r_zero),
      .fflags_clr_i(r_zero), .fflags_o(r_ff[g]), .usage_o(r_usage[g][UW-1:0]), .busy_o(r_busy[g])
    );
    if (UW < 3) begin : g_pad
      assign r_usage[g][2:UW] = '0;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    checks++; if (slc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", slc_ready); end
    checks++; if (usage !== 2'd0) begin errors++; $display("FAIL reset_usage: got %0d exp 0", usage); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (fflags !== 5'b00000) begin errors++; $display("FAIL reset_fflags: got %b exp 00000", fflags); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h exp 0", result); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_pop();
    slc_valid = 1'b1; slc_result = 64'h0000_0000_0000_00A1; slc_status = 5'b00001;
    slc_ext = 1'b1; slc_tag = 4'h5; out_ready = 1'b1;
    tick();
    slc_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid: got %b exp 1", out_valid); end
    checks++; if (result !== 64'h0000_0000_0000_00A1) begin errors++; $display("FAIL t1_result: got %h exp a1", result); end
    checks++; if (tag !== 4'h5) begin errors++; $display("FAIL t1_tag: got %h exp 5", tag); end
    checks++; if (ext !== 1'b1) begin errors++; $display("FAIL t1_ext: got %b exp 1", ext); end
    checks++; if (fflags !== 5'b00000) begin errors++; $display("FAIL t1_fflags_early: got %b exp 00000", fflags); end
    tick();
    checks++; if (fflags !== 5'b00001) begin errors++; $display("FAIL t1_fflags: got %b exp 00001", fflags); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_empty: got %b exp 0", out_valid); end
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    checks++; if (fflags !== 5'b00000) begin errors++; $display("FAIL t1_clr: got %b exp 00000", fflags); end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_q [3];
    int idx;
    logic acc;
    exp_q[0] = 64'hAAAA_0000_0000_0001;
    exp_q[1] = 64'hBBBB_0000_0000_0002;
    exp_q[2] = 64'hCCCC_0000_0000_0003;
    slc_status = 5'b00000; slc_ext = 1'b0;
    out_ready = 1'b0; slc_valid = 1'b1; slc_result = exp_q[0]; slc_tag = 4'h2;
    tick();
    slc_result = exp_q[1]; slc_tag = 4'h3;
    #1;
    checks++; if (slc_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_half: got %b exp 1", slc_ready); end
    tick();
    slc_result = exp_q[2]; slc_tag = 4'h4;
    #1;
    checks++; if (slc_ready !== 1'b0) begin errors++; $display("FAIL t2_ready_full: got %b exp 0", slc_ready); end
    checks++; if (usage !== 2'd2) begin errors++; $display("FAIL t2_usage: got %0d exp 2", usage); end
    tick();
    checks++; if (result !== exp_q[0]) begin errors++; $display("FAIL t2_hold: got %h exp %h", result, exp_q[0]); end
    checks++; if (tag !== 4'h2) begin errors++; $display("FAIL t2_hold_tag: got %h exp 2", tag); end
    out_ready = 1'b1;
    idx = 0;
    #1;
    for (int c = 0; c < 10; c++) begin
      acc = slc_valid && slc_ready;
      if (out_valid && out_ready) begin
        checks++;
        if (idx > 2) begin
          errors++; $display("FAIL t2_dup: got %h exp none", result);
        end else if (result !== exp_q[idx]) begin
          errors++; $display("FAIL t2_order[%0d]: got %h exp %h", idx, result, exp_q[idx]);
        end
        idx++;
      end
      tick();
      if (acc) slc_valid = 1'b0;
      #1;
    end
    checks++; if (idx !== 3) begin errors++; $display("FAIL t2_count: got %0d exp 3", idx); end
    checks++; if (slc_valid !== 1'b0) begin errors++; $display("FAIL t2_c_accepted: got %b exp 0", slc_valid); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0; slc_valid = 1'b1; slc_result = 64'd11;
    tick();
    slc_result = 64'd22;
    tick();
    slc_result = 64'd33; out_ready = 1'b1;
    #1;
    checks++; if (slc_ready !== 1'b0) begin errors++; $display("FAIL t3_full_ready: got %b exp 0", slc_ready); end
    tick();
    checks++; if (usage !== 2'd1) begin errors++; $display("FAIL t3_pop_only: got %0d exp 1", usage); end
    checks++; if (result !== 64'd22) begin errors++; $display("FAIL t3_head: got %0d exp 22", result); end
    tick();
    checks++; if (usage !== 2'd1) begin errors++; $display("FAIL t3_pushpop: got %0d exp 1", usage); end
    for (int i = 0; i < 10; i++) begin
      slc_result = 64'd100 + 64'(i);
      #1;
      checks++; if (usage !== 2'd1) begin errors++; $display("FAIL t3_wrap_usage[%0d]: got %0d exp 1", i, usage); end
      checks++;
      if (result !== ((i == 0) ? 64'd33 : 64'd99 + 64'(i))) begin
        errors++; $display("FAIL t3_wrap_data[%0d]: got %0d exp %0d", i, result, (i == 0) ? 33 : 99 + i);
      end
      tick();
    end
    slc_valid = 1'b0;
    #1;
    checks++; if (result !== 64'd109) begin errors++; $display("FAIL t3_last: got %0d exp 109", result); end
    tick();
    checks++; if (usage !== 2'd0) begin errors++; $display("FAIL t3_drained: got %0d exp 0", usage); end
  endtask

  task automatic test_flush();
    fflags_clr = 1'b1; tick(); fflags_clr = 1'b0;
    out_ready = 1'b0; slc_valid = 1'b1; slc_result = 64'd1; slc_status = 5'b10000;
    tick();
    slc_result = 64'd2; slc_status = 5'b00100;
    tick();
    slc_valid = 1'b0; flush = 1'b1;
    #1;
    checks++; if (slc_ready !== 1'b0) begin errors++; $display("FAIL t4_flush_ready: got %b exp 0", slc_ready); end
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t4_valid: got %b exp 0", out_valid); end
    checks++; if (usage !== 2'd0) begin errors++; $display("FAIL t4_usage: got %0d exp 0", usage); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_busy: got %b exp 0", busy); end
    checks++; if (fflags !== 5'b00000) begin errors++; $display("FAIL t4_fflags: got %b exp 00000", fflags); end
    // pop coinciding with flush still accumulates the popped status
    slc_valid = 1'b1; slc_status = 5'b10000; slc_result = 64'd3;
    tick();
    slc_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    checks++; if (fflags !== 5'b10000) begin errors++; $display("FAIL t4_flush_pop: got %b exp 10000", fflags); end
    checks++; if (usage !== 2'd0) begin errors++; $display("FAIL t4_flush_pop_usage: got %0d exp 0", usage); end
  endtask

  task automatic test_clear_on_pop();
    fflags_clr = 1'b1; tick(); fflags_clr = 1'b0;
    slc_valid = 1'b1; slc_status = 5'b00001;
    tick();
    slc_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (fflags !== 5'b00001) begin errors++; $display("FAIL t5_nx: got %b exp 00001", fflags); end
    slc_valid = 1'b1; slc_status = 5'b01000;
    tick();
    slc_valid = 1'b0; out_ready = 1'b1; fflags_clr = 1'b1;
    tick();
    out_ready = 1'b0; fflags_clr = 1'b0;
    checks++; if (fflags !== 5'b01000) begin errors++; $display("FAIL t5_clr_pop: got %b exp 01000", fflags); end
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    checks++; if (fflags !== 5'b00000) begin errors++; $display("FAIL t5_clr_only: got %b exp 00000", fflags); end
  endtask

  task automatic test_reset_mid();
    slc_valid = 1'b1; slc_status = 5'b00010; slc_result = 64'd7;
    tick();
    slc_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t7_pre: got %b exp 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t7_async_valid: got %b exp 0", out_valid); end
    checks++; if (usage !== 2'd0) begin errors++; $display("FAIL t7_async_usage: got %0d exp 0", usage); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int dep [3];
    logic [25:0] mdl [3][16];
    int mh [3];
    int mc [3];
    logic [4:0] mff [3];
    logic pend [3];
    logic [25:0] got;
    dep[0] = 1; dep[1] = 3; dep[2] = 4;
    for (int k = 0; k < 3; k++) begin
      mh[k] = 0; mc[k] = 0; mff[k] = 5'b00000; pend[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 2500; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        if (!pend[k]) begin
          r_vin[k]    = ($urandom_range(0, 99) < 60);
          r_res_in[k] = 16'($urandom);
          r_sts_in[k] = 5'($urandom);
          r_ext_in[k] = 1'($urandom);
          r_tag_in[k] = 4'($urandom);
        end
        r_rdy_in[k] = ($urandom_range(0, 99) < 55);
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++; if (r_usage[k] !== 3'(mc[k])) begin errors++; $display("FAIL t6_usage[%0d]: got %0d exp %0d", k, r_usage[k], mc[k]); end
        checks++; if (r_busy[k] !== (r_usage[k] != 3'd0)) begin errors++; $display("FAIL t6_busy[%0d]: got %b usage %0d", k, r_busy[k], r_usage[k]); end
        checks++; if (r_vout[k] !== (mc[k] != 0)) begin errors++; $display("FAIL t6_valid[%0d]: got %b exp %b", k, r_vout[k], mc[k] != 0); end
        checks++; if (r_rdy_o[k] !== (mc[k] != dep[k])) begin errors++; $display("FAIL t6_ready[%0d]: got %b exp %b", k, r_rdy_o[k], mc[k] != dep[k]); end
        checks++; if (r_ff[k] !== mff[k]) begin errors++; $display("FAIL t6_fflags[%0d]: got %b exp %b", k, r_ff[k], mff[k]); end
        if (r_vout[k] && r_rdy_in[k] && mc[k] != 0) begin
          got = {r_res[k], r_sts[k], r_ext[k], r_tag[k]};
          checks++;
          if (got !== mdl[k][mh[k]]) begin
            errors++; $display("FAIL t6_data[%0d]: got %h exp %h", k, got, mdl[k][mh[k]]);
          end
          mff[k] = mff[k] | mdl[k][mh[k]][9:5];
          mh[k] = (mh[k] + 1) % dep[k];
          mc[k]--;
        end
        if (r_vin[k] && r_rdy_o[k]) begin
          mdl[k][(mh[k] + mc[k]) % dep[k]] = {r_res_in[k], r_sts_in[k], r_ext_in[k], r_tag_in[k]};
          mc[k]++;
          pend[k] = 1'b0;
        end else begin
          pend[k] = r_vin[k];
        end
      end
      tick();
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; slc_result = 64'd0; slc_status = 5'b00000; slc_ext = 1'b0; slc_tag = 4'h0;
    slc_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; fflags_clr = 1'b0; r_zero = 1'b0;
    for (int k = 0; k < 3; k++) begin
      r_res_in[k] = 16'd0; r_sts_in[k] = 5'd0; r_ext_in[k] = 1'b0; r_tag_in[k] = 4'd0;
      r_vin[k] = 1'b0; r_rdy_in[k] = 1'b0;
    end
    test_reset();
    test_single_pop();
    test_backpressure();
    test_full_pop();
    test_flush();
    test_clear_on_pop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
